// File: rtl/minisys_pkg.sv
// Shared definitions for the minisys pipeline blocks: fetch FSM encoding,
// default reset vector, major opcodes and the branch displacement helper.
package minisys_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // Word-scaled, sign-extended 16-bit branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch32_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface ifetch32_stage_if #(
  parameter int AW = 14
) ();

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/ifetch32_stage_npc.sv
// Combinational next-PC resolution for the held instruction; also flags a
// misaligned jr target.
module ifetch_npc
  import minisys_pkg::*;
(
  input  logic [31:0] pc_plus_4_i,
  input  logic [25:0] instr_idx_i,
  input  logic        jrn_i,
  input  logic        jmp_i,
  input  logic        jal_i,
  input  logic        branch_i,
  input  logic        nbranch_i,
  input  logic        zero_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] npc_o,
  output logic        misalign_o
);

  logic branch_taken;

  assign branch_taken = (branch_i & zero_i) | (nbranch_i & ~zero_i);

  // NOTE: every output gets a default before the priority chain, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    npc_o      = pc_plus_4_i;
    misalign_o = 1'b0;
    if (jrn_i) begin
      npc_o      = {rs_val_i[31:2], 2'b00};
      misalign_o = |rs_val_i[1:0];
    end else if (jmp_i | jal_i) begin
      npc_o = {pc_plus_4_i[31:28], instr_idx_i, 2'b00};
    end else if (branch_taken) begin
      npc_o = pc_plus_4_i + branch_offset(instr_idx_i[15:0]);
    end
  end

endmodule

// File: rtl/ifetch32_stage.sv
// Multi-cycle instruction fetch stage: IDLE -> REQ -> WAIT -> HOLD loop.
// Optional build macro IFETCH_PERF_CNT_EN adds fetch/redirect counters.
module ifetch32_stage
  import minisys_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_WIDTH = 14
) (
  input  logic                     clock,
  input  logic                     reset,
  ifetch32_stage_if.master         imem,
  input  logic                     Jrn,
  input  logic                     Jmp,
  input  logic                     Jal,
  input  logic                     Branch,
  input  logic                     nBranch,
  input  logic                     Zero,
  input  logic [31:0]              Read_data_1,
  input  logic                     exec_done,
  output logic [31:0]              Instruction,
  output logic                     insn_valid,
  output logic [31:0]              PC,
  output logic [31:0]              PC_plus_4,
  output logic                     fetch_misalign
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              redirect_count
`endif
);

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          misalign_q, misalign_d;

  logic [31:0]   pc_plus_4;
  logic [31:0]   npc;
  logic          npc_misalign;
  logic          advance;
  logic          capture;

  assign pc_plus_4 = pc_q + 32'd4;
  assign advance   = (state_q == HOLD) & exec_done;
  assign capture   = (state_q == WAIT) & imem.imem_valid;

  ifetch_npc u_npc (
    .pc_plus_4_i (pc_plus_4),
    .instr_idx_i (instr_q[25:0]),
    .jrn_i       (Jrn),
    .jmp_i       (Jmp),
    .jal_i       (Jal),
    .branch_i    (Branch),
    .nbranch_i   (nBranch),
    .zero_i      (Zero),
    .rs_val_i    (Read_data_1),
    .npc_o       (npc),
    .misalign_o  (npc_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (capture) begin
          instr_d = imem.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d       = npc;
          misalign_d = misalign_q | npc_misalign;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (capture) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (advance && (npc != pc_plus_4)) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign fetch_count    = fetch_cnt_q;
  assign redirect_count = redirect_cnt_q;
`endif

  // Request strobe and valid flag decode straight from the state, so they
  // are low out of reset and never glitch against the registered state.
  assign imem.imem_req   = (state_q == REQ);
  assign imem.imem_addr  = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign insn_valid      = (state_q == HOLD);
  assign Instruction     = instr_q;
  assign PC              = pc_q;
  assign PC_plus_4       = pc_plus_4;
  assign fetch_misalign  = misalign_q;

endmodule
